// File: rtl/dsp_27x27s_rr_sched.sv
// Round-robin scheduler sharing one pipelined signed 27x27 multiplier among NUM_REQ requesters.
// Optional performance counters (perf_issued, perf_stall, perf_clr) are built when DSP27_SCHED_PERF_EN is defined.

module dsp_27x27s #(
  parameter string FAMILY  = "Agilex",
  parameter int    LATENCY = 4
) (
  input  logic               clk,
  input  logic signed [26:0] ax,
  input  logic signed [26:0] ay,
  output logic signed [53:0] res
);

  localparam int MAX_LAT = (FAMILY == "Agilex") ? 8 : 4;

  if (LATENCY < 1 || LATENCY > MAX_LAT) begin : g_bad_latency
    $error("dsp_27x27s: LATENCY out of range for FAMILY");
  end

  logic signed [26:0] ax_p0;
  logic signed [26:0] ay_p0;
  logic signed [53:0] mult_p0;

  always_ff @(posedge clk) begin
    ax_p0 <= ax;
    ay_p0 <= ay;
  end

  // stage 0 -> 1: full-precision product of the registered operands
  assign mult_p0 = $signed({{27{ax_p0[26]}}, ax_p0}) * $signed({{27{ay_p0[26]}}, ay_p0});

  if (LATENCY == 1) begin : g_lat1
    assign res = mult_p0;
  end else begin : g_pipe
    logic signed [53:0] prod_pn [1:LATENCY-1];

    always_ff @(posedge clk) begin
      prod_pn[1] <= mult_p0;
      for (int k = 2; k < LATENCY; k++) begin
        prod_pn[k] <= prod_pn[k-1];
      end
    end

    assign res = prod_pn[LATENCY-1];
  end

endmodule

module dsp_27x27s_rr_sched #(
  parameter string FAMILY  = "Agilex",
  parameter int    LATENCY = 4,
  parameter int    NUM_REQ = 4,
  parameter int    ID_W    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*27-1:0]          req_ax,
  input  logic [NUM_REQ*27-1:0]          req_ay,
  input  logic                           issue_en,
  output logic                           res_valid,
  output logic [ID_W-1:0]                res_id,
  output logic signed [53:0]             res_data,
`ifdef DSP27_SCHED_PERF_EN
  input  logic                           perf_clr,
  output logic [31:0]                    perf_issued,
  output logic [31:0]                    perf_stall,
`endif
  output logic                           busy,
  output logic [$clog2(LATENCY+1)-1:0]   inflight
);

  localparam int CNT_W = $clog2(LATENCY+1);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_id;
  logic               grant_vld;
  logic [ID_W:0]      scan_idx;
  logic signed [26:0] ax_sel;
  logic signed [26:0] ay_sel;

  // Reset also blocks grants so nothing is accepted while the pipeline is being cleared.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    if (issue_en && rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
        if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
          scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
        end
        if (!grant_vld && req_valid[scan_idx[ID_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_id  = scan_idx[ID_W-1:0];
        end
      end
    end
  end

  assign req_ready = grant_vld ? (NUM_REQ'(1) << grant_id) : '0;

  always_comb begin
    ax_sel = '0;
    ay_sel = '0;
    if (grant_vld) begin
      ax_sel = $signed(req_ax[27*int'(grant_id) +: 27]);
      ay_sel = $signed(req_ay[27*int'(grant_id) +: 27]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
    end
  end

  dsp_27x27s #(
    .FAMILY  (FAMILY),
    .LATENCY (LATENCY)
  ) u_dsp (
    .clk (clk),
    .ax  (ax_sel),
    .ay  (ay_sel),
    .res (res_data)
  );

  // Tag pipeline: one stage per multiplier register, masks stale products after reset
  logic            vld_pn [LATENCY];
  logic [ID_W-1:0] id_pn  [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LATENCY; k++) begin
        vld_pn[k] <= 1'b0;
        id_pn[k]  <= '0;
      end
    end else begin
      vld_pn[0] <= grant_vld;
      id_pn[0]  <= grant_vld ? grant_id : '0;
      for (int k = 1; k < LATENCY; k++) begin
        vld_pn[k] <= vld_pn[k-1];
        id_pn[k]  <= id_pn[k-1];
      end
    end
  end

  assign res_valid = vld_pn[LATENCY-1];
  assign res_id    = id_pn[LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({grant_vld, res_valid})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign busy = (inflight != '0);

`ifdef DSP27_SCHED_PERF_EN
  logic stall;

  assign stall = (|req_valid) && !grant_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else if (perf_clr) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (grant_vld) perf_issued <= perf_issued + 32'd1;
      if (stall)     perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dsp_27x27s_rr_sched.sv
// Scoreboard bench for dsp_27x27s_rr_sched (NUM_REQ=4, LATENCY=4); covers DSP27_SCHED_PERF_EN when defined.

module tb_dsp_27x27s_rr_sched;

  localparam int LAT = 4;
  localparam int NR  = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [NR-1:0]      req_valid = '0;
  logic [NR-1:0]      req_ready;
  logic [NR*27-1:0]   req_ax;
  logic [NR*27-1:0]   req_ay;
  logic               issue_en = 1'b0;
  logic               res_valid;
  logic [1:0]         res_id;
  logic signed [53:0] res_data;
  logic               busy;
  logic [2:0]         inflight;
`ifdef DSP27_SCHED_PERF_EN
  logic               perf_clr = 1'b0;
  logic [31:0]        perf_issued;
  logic [31:0]        perf_stall;
`endif

  dsp_27x27s_rr_sched #(
    .FAMILY  ("Agilex"),
    .LATENCY (LAT),
    .NUM_REQ (NR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ax    (req_ax),
    .req_ay    (req_ay),
    .issue_en  (issue_en),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data),
`ifdef DSP27_SCHED_PERF_EN
    .perf_clr    (perf_clr),
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall),
`endif
    .busy      (busy),
    .inflight  (inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]         id;
    logic signed [53:0] data;
    int                 cyc;
  } exp_t;

  exp_t               sb[$];
  exp_t               mon_e;
  int                 total = 0;
  int                 bad = 0;
  int                 cyc = 0;
  logic signed [26:0] op_x [NR];
  logic signed [26:0] op_y [NR];
  logic signed [53:0] prod_tab [NR];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Each accepted operation is expected back LAT cycles later in issue order.
  always @(negedge clk) begin
    if (res_valid) begin
      if (sb.size() == 0) begin
        check("res_unexpected", 64'(res_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("res_id", 64'(res_id), 64'(mon_e.id));
        check("res_data", res_data, mon_e.data);
        check("res_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic step(input logic [NR-1:0] v, input logic en, input logic [NR-1:0] exp_rdy,
                      input bit do_push);
    exp_t e;
    @(negedge clk);
    req_valid = v;
    issue_en  = en;
    #1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    for (int i = 0; i < NR; i++) begin
      if (exp_rdy[i] && do_push) begin
        e.id   = 2'(i);
        e.data = prod_tab[i];
        e.cyc  = cyc + LAT;
        sb.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    #1;
    rst_n     = 1'b0;
    req_valid = '1;
    issue_en  = 1'b1;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_id", 64'(res_id), 64'd0);
    check("rst_inflight", 64'(inflight), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached limit, pending=%0d", $time, sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    op_x[0] = 27'sd7;       op_y[0] = 27'sd11;      prod_tab[0] = 54'sd77;
    op_x[1] = 27'sd67108863; op_y[1] = 27'h4000000; prod_tab[1] = -54'sd4503599560261632;
    op_x[2] = 27'sd3;       op_y[2] = -27'sd5;      prod_tab[2] = -54'sd15;
    op_x[3] = 27'h4000000;  op_y[3] = 27'h4000000;  prod_tab[3] = 54'sd4503599627370496;
    for (int i = 0; i < NR; i++) begin
      req_ax[27*i +: 27] = op_x[i];
      req_ay[27*i +: 27] = op_y[i];
    end

    do_reset();

    // single request from requester 2
    step(4'b0100, 1'b1, 4'b0100, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step(4'b0000, 1'b1, 4'b0000, 1'b1);
      check("inflight_single", 64'(inflight), (k <= 4) ? 64'd1 : 64'd0);
      check("busy_single", 64'(busy), (k <= 4) ? 64'd1 : 64'd0);
    end

    // full contention from rr_ptr=0
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 1'b1, 4'b0001 << (k % 4), 1'b1);
      if (k >= 4) check("inflight_full", 64'(inflight), 64'd4);
    end
    for (int k = 0; k < 6; k++) step(4'b0000, 1'b1, 4'b0000, 1'b1);

    // issue_en dropped in cycle 5 under full load
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k < 5) step(4'b1111, 1'b1, 4'b0001 << (k % 4), 1'b1);
      else       step(4'b1111, 1'b0, 4'b0000, 1'b1);
      if (k == 8) check("busy_tail", 64'(busy), 64'd1);
      if (k == 9) begin
        check("busy_drained", 64'(busy), 64'd0);
        check("inflight_drained", 64'(inflight), 64'd0);
      end
    end

    // reset with three operations in flight
    do_reset();
    for (int k = 0; k < 3; k++) step(4'b1111, 1'b1, 4'b0001 << k, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);
    check("inflight_before_rst", 64'(inflight), 64'd3);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(4'b0000, 1'b1, 4'b0000, 1'b1);
      check("res_valid_after_rst", 64'(res_valid), 64'd0);
    end
    step(4'b1010, 1'b1, 4'b0010, 1'b1);
    for (int k = 0; k < 6; k++) step(4'b0000, 1'b1, 4'b0000, 1'b1);

`ifdef DSP27_SCHED_PERF_EN
    do_reset();
    check("perf_issued_rst", 64'(perf_issued), 64'd0);
    check("perf_stall_rst", 64'(perf_stall), 64'd0);
    step(4'b0111, 1'b0, 4'b0000, 1'b1);
    step(4'b0111, 1'b0, 4'b0000, 1'b1);
    step(4'b0111, 1'b1, 4'b0001, 1'b1);
    step(4'b0111, 1'b1, 4'b0010, 1'b1);
    step(4'b0111, 1'b1, 4'b0100, 1'b1);
    step(4'b0111, 1'b1, 4'b0001, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b1);
    check("perf_issued", 64'(perf_issued), 64'd4);
    check("perf_stall", 64'(perf_stall), 64'd2);
    @(negedge clk);
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    check("perf_issued_clr", 64'(perf_issued), 64'd0);
    check("perf_stall_clr", 64'(perf_stall), 64'd0);
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsp_27x27s_rr_sched.md
Name: dsp_27x27s_rr_sched

Overview:
- Round-robin scheduler that shares one signed 27x27 DSP multiplier (dsp_27x27s, instantiated internally) between NUM_REQ requesters.
- Accepts at most one operand pair per cycle over valid/ready handshakes and issues it into the pipelined multiplier.
- Carries the requester ID through a tag pipeline matched to the multiplier latency, and returns each product with its ID.
- Sits between multiple filter/accumulator clients and a single hard DSP block.

Parameters:
- FAMILY, "Agilex", target family; passed to dsp_27x27s.
- LATENCY, 4, multiplier latency in cycles; passed to dsp_27x27s. Legal range is that of dsp_27x27s for FAMILY.
- NUM_REQ, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(NUM_REQ), width of the requester ID.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_ax  in  NUM_REQ*27  packed signed operand X; requester i occupies bits [27*i+26:27*i]
- req_ay  in  NUM_REQ*27  packed signed operand Y; same packing as req_ax
- issue_en  in  1  when 0, no new operations are accepted; in-flight operations still complete
- res_valid  out  1  product valid
- res_id  out  ID_W  requester index of the product
- res_data  out  54  signed product ax*ay
- busy  out  1  at least one operation in flight
- inflight  out  $clog2(LATENCY+1)  number of operations in flight

Behaviour:
- Reset (rst_n low, asynchronous):
  - rr_ptr=0, tag pipeline valid bits=0, inflight=0, busy=0.
  - res_valid=0, res_id=0, req_ready=0.
  - res_data is don't-care while res_valid=0.
- Arbitration (combinational, each cycle):
  - If issue_en=0 or req_valid=0: no grant.
  - Otherwise grant g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready = one-hot(g) when a grant exists, else 0. req_ready may depend combinationally on req_valid and issue_en.
- Issue:
  - A handshake (req_valid[g] & req_ready[g]) at the rising edge ending cycle c:
    - loads the granted operands into the multiplier;
    - pushes tag {valid=1, id=g} into the tag pipeline;
    - updates rr_ptr to (g+1) mod NUM_REQ.
  - No handshake: rr_ptr holds, and a bubble (valid=0) is pushed. The multiplier inputs are driven to 0 for bubbles.
- Latency:
  - The operation accepted in cycle c appears in cycle c+LATENCY with res_valid=1, res_id=g, res_data=ax*ay (full-precision signed).
  - res_valid is high for exactly one cycle per accepted operation. Throughput is 1 operation per cycle.
  - No output backpressure: consumers must accept a result whenever res_valid=1.
- Tag pipeline: LATENCY stages, reset to valid=0, aligned exactly with the multiplier registers.
- Inflight counter:
  - +1 on issue, -1 when res_valid; unchanged when both or neither occur.
  - Saturation is impossible; the maximum value is LATENCY.
  - busy = (inflight != 0).
- Fairness: a requester holding req_valid high is granted within NUM_REQ cycles while issue_en=1.
- Requester rules: req_ax/req_ay must be stable while req_valid=1 and not yet accepted. Deasserting req_valid before acceptance is permitted (no grant is lost or remembered).
- issue_en falling mid-stream: accepted operations still return; no new grants from the next cycle onward.
- Reset mid-operation: all in-flight operations are discarded, and no res_valid is produced for them after reset release. Garbage left in the multiplier registers is masked by the tag pipeline.

Optional Feature:
- Macro DSP27_SCHED_PERF_EN.
- Defined: adds outputs perf_issued (32 bits, counts handshakes) and perf_stall (32 bits, counts cycles with req_valid!=0 and no grant).
  - Both counters reset to 0 by rst_n and wrap modulo 2^32.
  - Adds input perf_clr (1 bit); perf_clr=1 synchronously zeroes both counters, with priority over increment.
- Undefined: these ports and the counter logic do not exist; all other behaviour is identical.

Test Plan:
- Single request: NUM_REQ=4, LATENCY=4, requester 2 sends ax=3, ay=-5 in cycle 10 -> res_valid=1 in cycle 14 only, res_id=2, res_data=-15; inflight=1 during cycles 11..14.
- Full contention: all 4 requesters valid continuously from cycle 0 with rr_ptr=0 -> grants 0,1,2,3,0,1... in cycles 0..7; results return in the same order in cycles 4..11, each with the matching product.
- Extremes: ax=-2^26, ay=-2^26 -> res_data=2^52. ax=2^26-1, ay=-2^26 -> res_data=-(2^52-2^26).
- issue_en dropped in cycle 5 under full load -> req_ready=0 from cycle 5; results of the 5 operations accepted in cycles 0..4 still arrive in cycles 4..8; busy=0 from cycle 9.
- Reset pulse in cycle 6 with 3 operations in flight -> res_valid stays 0 thereafter until new issues; rr_ptr=0, inflight=0 immediately.
- With DSP27_SCHED_PERF_EN: 3 requesters valid for 6 cycles with issue_en=0 for the first 2 -> perf_issued=4, perf_stall=2; perf_clr pulse -> both counters 0 next cycle.
